// File: rtl/seg7_scan_ctrl_if.sv
// Display bus between the datapath and the 7-segment scan controller:
// value/load strobe in, frame pulse plus multiplexed cathode and anode pins out.
interface seg7_scan_ctrl_if;
    logic [31:0] Data;
    logic        Load;
    logic        Frame_done;
    logic [6:0]  out7;
    logic [7:0]  en_out;

    modport master (output Data, Load, input Frame_done, out7, en_out);
    modport slave  (input Data, Load, output Frame_done, out7, en_out);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Double-buffered 8-digit hex scanner driving a shared active-low 7-segment bus.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits 1..7.
module seg7_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic             Clk,
    input  logic             Rst,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int unsigned        DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       dig;
    logic [31:0]      disp;
    logic [31:0]      pend;
    logic             pend_v;

    logic             slot_end;
    logic             frame_end;
    logic [3:0]       nib;
    logic [6:0]       seg;
    logic             lead_zero;

    logic [6:0]       out7_q;
    logic [7:0]       en_out_q;
    logic             frame_done_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h7F;
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            4'hF: hex7 = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (dig == 3'd7);

    // Slot timer and digit pointer; dig wraps 7->0 naturally in 3 bits.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge state.
        if (!Rst) begin
            div_cnt <= '0;
            dig     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            dig     <= dig + 3'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Pending buffer absorbs loads mid-frame; disp only moves at the frame boundary,
    // where a load on that same edge bypasses pend and wins.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: the data buffers are reset too, so the first frame shows a defined 0.
        if (!Rst) begin
            disp   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else if (frame_end) begin
            if (bus.Load)
                disp <= bus.Data;
            else if (pend_v)
                disp <= pend;
            pend_v <= 1'b0;
        end else if (bus.Load) begin
            pend   <= bus.Data;
            pend_v <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch behind.
        nib       = disp[{dig, 2'b00} +: 4];
        seg       = hex7(nib);
        lead_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero = (dig != 3'd0) && ((disp >> {dig, 2'b00}) == 32'd0);
`endif
    end

    // Registered pins: the guard cycle at div_cnt==0 blanks everything to stop ghosting.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out7_q       <= 7'h7F;
            en_out_q     <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if ((div_cnt == '0) || lead_zero) begin
                en_out_q <= 8'hFF;
                out7_q   <= 7'h7F;
            end else begin
                en_out_q <= ~(8'd1 << dig);
                out7_q   <= seg;
            end
        end
    end

    assign bus.out7       = out7_q;
    assign bus.en_out     = en_out_q;
    assign bus.Frame_done = frame_done_q;

endmodule
